approx_mult_pipe: RTL and testbench



---
 rtl/approx_mult_pipe.sv | 127 ++++++++++++
 tb/tb_approx_mult_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe
//   Pipelined unsigned approximate multiplier built from 4x4 nibble tiles.
//   A per-beat mode selects which tiles have their low TRUNC bits cleared.
//   Three register stages: S1 operands, S2 truncated tile products, S3 sum.
//
// Parameters
//   WIDTH  operand width (multiple of 4, >= 8); K = WIDTH/4 nibbles
//   TRUNC  LSBs cleared in an approximate tile product (0..7)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand beat handshake (in_ready = ~stall)
//   in_a, in_b          unsigned operands
//   in_mode             0 exact, 1 low tiles approx, 2 all but top tile approx,
//                       3 reserved (exact, reported back as 3)
//   out_valid/out_ready result handshake
//   out_r               2*WIDTH-bit product
//   out_mode            mode carried with the result
module approx_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int TRUNC = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_r,
  output logic [1:0]           out_mode
);

  localparam int unsigned K  = WIDTH / 4;
  localparam int unsigned NT = K * K;
  localparam int RW = 2 * WIDTH;
  localparam logic [7:0] TMASK = 8'hFF << TRUNC;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'd0,
    MODE_LOW   = 2'd1,
    MODE_HIGH  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  logic             stall;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  mode_e            s1_mode;

  logic             s2_valid;
  logic [NT*8-1:0]  s2_tiles;
  mode_e            s2_mode;

  logic [NT*8-1:0]  tile_next;
  logic [RW-1:0]    sum_next;

  // Whole pipe freezes while the output is held; nothing moves, nothing drops.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  function automatic logic tile_is_approx(mode_e m, int unsigned i, int unsigned j);
    logic r;
    r = 1'b0;
    case (m)
      MODE_LOW:  r = (i + j) < (K - 1);
      MODE_HIGH: r = !((i == K - 1) && (j == K - 1));
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

  // S1 -> S2: all K*K tile products, truncated per mode.
  always_comb begin
    tile_next = '0;
    for (int unsigned i = 0; i < K; i++) begin
      for (int unsigned j = 0; j < K; j++) begin
        logic [7:0] p;
        p = 8'(s1_a[4*i +: 4]) * 8'(s1_b[4*j +: 4]);
        if (tile_is_approx(s1_mode, i, j))
          p = p & TMASK;
        tile_next[(i*K + j)*8 +: 8] = p;
      end
    end
  end

  // S2 -> S3: weighted adder tree of the tiles.
  always_comb begin
    sum_next = '0;
    for (int unsigned i = 0; i < K; i++) begin
      for (int unsigned j = 0; j < K; j++) begin
        sum_next = sum_next + (RW'(s2_tiles[(i*K + j)*8 +: 8]) << (4*(i + j)));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_mode   <= MODE_EXACT;
      s2_valid  <= 1'b0;
      s2_tiles  <= '0;
      s2_mode   <= MODE_EXACT;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_mode  <= '0;
    end else if (!stall) begin
      s1_valid  <= in_valid;
      s1_a      <= in_a;
      s1_b      <= in_b;
      s1_mode   <= mode_e'(in_mode);
      s2_valid  <= s1_valid;
      s2_tiles  <= tile_next;
      s2_mode   <= s1_mode;
      out_valid <= s2_valid;
      out_r     <= sum_next;
      out_mode  <= s2_mode;
    end
  end

endmodule

// File: tb/tb_approx_mult_pipe.sv
module tb_approx_mult_pipe;

  localparam int T = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v8, r8, ov8, ordy8;
  logic [7:0]  a8, b8;
  logic [1:0]  m8, om8;
  logic [15:0] or8;

  logic        v16, r16, ov16, ordy16;
  logic [15:0] a16, b16;
  logic [1:0]  m16, om16;
  logic [31:0] or16;

  approx_mult_pipe #(.WIDTH(8), .TRUNC(T)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .in_a(a8), .in_b(b8),
    .in_mode(m8), .out_valid(ov8), .out_ready(ordy8), .out_r(or8), .out_mode(om8)
  );

  approx_mult_pipe #(.WIDTH(16), .TRUNC(T)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16), .in_a(a16), .in_b(b16),
    .in_mode(m16), .out_valid(ov16), .out_ready(ordy16), .out_r(or16), .out_mode(om16)
  );

  int ncmp = 0;
  int nerr = 0;
  int acc16 = 0;

  typedef struct {
    longint     a;
    longint     b;
    longint     exp;
    logic [1:0] m;
  } beat_t;

  beat_t q8[$];
  beat_t q16[$];
  beat_t e8, e16;

  // Reference: exact product minus the bits lost in each approximate tile.
  function automatic bit approx_tile(int mode, int i, int j, int k);
    return (mode == 1 && i + j < k - 1) || (mode == 2 && !(i == k - 1 && j == k - 1));
  endfunction

  function automatic longint model(longint a, longint b, int mode, int k);
    longint r;
    r = a * b;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        if (approx_tile(mode, i, j, k))
          r -= ((((a >> (4*i)) & 15) * ((b >> (4*j)) & 15)) % (1 << T)) << (4*(i+j));
    return r;
  endfunction

  function automatic longint err_bound(int mode, int k);
    longint s;
    s = 0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        if (approx_tile(mode, i, j, k))
          s += longint'((1 << T) - 1) << (4*(i+j));
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard push: a beat is taken at the next rising edge when valid & ready.
  always @(negedge clk) begin
    if (rst_n) begin
      if (v8 && r8)
        q8.push_back('{longint'(a8), longint'(b8), model(longint'(a8), longint'(b8), int'(m8), 2), m8});
      if (v16 && r16) begin
        q16.push_back('{longint'(a16), longint'(b16), model(longint'(a16), longint'(b16), int'(m16), 4), m16});
        acc16++;
      end
    end
  end

  // Monitor: pop and compare whenever a result is handed over.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ov8 && ordy8) begin
        if (q8.size() == 0) check("dut8 unexpected result", 64'd1, 64'd0);
        else begin
          e8 = q8.pop_front();
          check("dut8 product", 64'(or8), e8.exp);
          check("dut8 out_mode", 64'(om8), 64'(e8.m));
        end
      end
      if (ov16 && ordy16) begin
        if (q16.size() == 0) check("dut16 unexpected result", 64'd1, 64'd0);
        else begin
          e16 = q16.pop_front();
          check("dut16 product", 64'(or16), e16.exp);
          check("dut16 out_mode", 64'(om16), 64'(e16.m));
          if (e16.m == 2'd0)
            check("dut16 mode0 exact", 64'(or16), e16.a * e16.b);
          if (e16.m == 2'd2)
            check("dut16 mode2 error bound",
                  64'((e16.a * e16.b - longint'(or16)) >= 0 &&
                      (e16.a * e16.b - longint'(or16)) <= err_bound(2, 4)), 64'd1);
        end
      end
    end
  end

  // Issue one beat on an idle pipe and measure edges until out_valid.
  task automatic send_one8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                           output int lat);
    v8 = 1'b1; a8 = a; b8 = b; m8 = m;
    @(posedge clk); #1 v8 = 1'b0;
    lat = 1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (ov8) break;
      @(posedge clk);
      lat++;
    end
  endtask

  logic [15:0] mode_exp [4];
  logic [7:0]  bp_a [4];
  logic [7:0]  bp_b [4];
  int          lat;
  logic [15:0] frozen;
  bit          seen;

  initial begin
    mode_exp[0] = 16'hFE01; mode_exp[1] = 16'hFE00;
    mode_exp[2] = 16'hFDE0; mode_exp[3] = 16'hFE01;
    v8 = 1'b0; a8 = '0; b8 = '0; m8 = '0; ordy8 = 1'b1;
    v16 = 1'b0; a16 = '0; b16 = '0; m16 = '0; ordy16 = 1'b1;

    // Reset held with in_valid high
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    repeat (2) begin
      @(negedge clk);
      check("reset out_valid", 64'(ov8), 64'd0);
      check("reset out_r", 64'(or8), 64'd0);
      check("reset in_ready", 64'(r8), 64'd1);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // Mode table, a=b=0xFF; first beat right after reset
    for (int m = 0; m < 4; m++) begin
      send_one8(8'hFF, 8'hFF, 2'(m), lat);
      check($sformatf("mode%0d latency", m), 64'(lat), 64'd3);
      check($sformatf("mode%0d product", m), 64'(or8), 64'(mode_exp[m]));
      check($sformatf("mode%0d out_mode", m), 64'(om8), 64'(m));
      @(posedge clk); #1;
    end

    // Back-to-back streaming
    v8 = 1'b1; m8 = 2'd0; a8 = 8'h03; b8 = 8'h05;
    @(posedge clk); #1 a8 = 8'h10; b8 = 8'h10;
    @(posedge clk); #1 a8 = 8'hA5; b8 = 8'h5A;
    @(posedge clk); #1 v8 = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (ov8) begin seen = 1'b1; break; end
    end
    check("stream first valid", 64'(seen), 64'd1);
    check("stream r0", 64'(or8), 64'h000F);
    @(negedge clk); check("stream r1", 64'(or8), 64'h0100);
    @(negedge clk); check("stream r2", 64'(or8), 64'h3A02);
    @(posedge clk); #1;

    // Backpressure: three beats fill the pipe, then out_ready low for 4 cycles
    for (int i = 0; i < 4; i++) begin bp_a[i] = 8'($urandom); bp_b[i] = 8'($urandom); end
    ordy8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v8 = 1'b1; a8 = bp_a[i]; b8 = bp_b[i]; m8 = 2'd0;
      @(posedge clk); #1;
    end
    a8 = bp_a[3]; b8 = bp_b[3]; m8 = 2'd1;
    frozen = 16'(model(longint'(bp_a[0]), longint'(bp_b[0]), 0, 2));
    repeat (4) begin
      @(negedge clk);
      check("stall in_ready", 64'(r8), 64'd0);
      check("stall out_valid", 64'(ov8), 64'd1);
      check("stall out_r frozen", 64'(or8), 64'(frozen));
    end
    @(posedge clk); #1 ordy8 = 1'b1;
    @(negedge clk);
    check("release in_ready", 64'(r8), 64'd1);
    @(posedge clk); #1 v8 = 1'b0;
    repeat (6) @(posedge clk);
    check("backpressure drained", 64'(q8.size()), 64'd0);
    #1;

    // Mid-stream reset with two beats in flight
    for (int i = 0; i < 2; i++) begin
      v8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); m8 = 2'd0;
      @(posedge clk); #1;
    end
    v8 = 1'b0;
    @(posedge clk); #1;
    check("pre-reset out_valid", 64'(ov8), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", 64'(ov8), 64'd0);
    check("async reset out_r", 64'(or8), 64'd0);
    check("async reset in_ready", 64'(r8), 64'd1);
    q8.delete(); q16.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("discarded beats absent", 64'(ov8), 64'd0);
    end
    @(posedge clk); #1;

    // Random regression on both widths with random backpressure
    for (int c = 0; c < 80000 && acc16 < 10000; c++) begin
      v8 = ($urandom_range(0, 3) != 0); a8 = 8'($urandom); b8 = 8'($urandom);
      m8 = 2'($urandom_range(0, 3)); ordy8 = ($urandom_range(0, 3) != 0);
      v16 = ($urandom_range(0, 3) != 0); a16 = 16'($urandom); b16 = 16'($urandom);
      m16 = 2'($urandom_range(0, 3)); ordy16 = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    v8 = 1'b0; v16 = 1'b0; ordy8 = 1'b1; ordy16 = 1'b1;
    for (int n = 0; n < 50 && (q8.size() != 0 || q16.size() != 0); n++)
      @(posedge clk);
    check("regression beat count", 64'(acc16 >= 10000), 64'd1);
    check("dut8 queue drained", 64'(q8.size()), 64'd0);
    check("dut16 queue drained", 64'(q16.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
